his_peak_scheduler: RTL and testbench

// - Post-acquisition sequencer for the histogram SRAM. On a start pulse from the histogram

---
 rtl/his_peak_scheduler.sv | 150 +++++++++++++++
 tb/tb_his_peak_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/his_peak_scheduler.sv
// rtl/his_peak_scheduler.sv - histogram SRAM scan sequencer reporting per-pixel peak bin/count
// Optional CLEAR_ON_READ_EN: zero each bin through port a one cycle after it is read.
module his_peak_scheduler #(
    parameter int BIN_NUM   = 16,
    parameter int PIXEL_NUM = 4,
    parameter int CNT_W     = 8,
    parameter int NB_W      = 4,
    parameter int PIX_W     = 2,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [CNT_W-1:0]  counts,
    output logic [ADDR_W-1:0] raddr,
    output logic              rEnable,
    output logic              readFlag,
    output logic [ADDR_W-1:0] waddr,
    output logic              wEnable,
    output logic              writeFlag,
    output logic [CNT_W-1:0]  newCounts,
    output logic              bld_hold,
    output logic              peak_valid,
    output logic [PIX_W-1:0]  peak_pixel,
    output logic [NB_W-1:0]   peak_bin,
    output logic [CNT_W-1:0]  peak_count,
    output logic              scan_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [NB_W-1:0]   LAST_BIN = NB_W'(BIN_NUM - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(PIXEL_NUM - 1);
    localparam logic [ADDR_W-1:0] BIN_STEP = ADDR_W'(BIN_NUM);

    logic [1:0]        state;
    logic [NB_W-1:0]   binCnt;
    logic [PIX_W-1:0]  pixCnt;
    logic [ADDR_W-1:0] pixBase;

    // Read-side tags delayed one cycle so they line up with counts.
    logic              rdValid;
    logic [NB_W-1:0]   binD;
    logic [PIX_W-1:0]  pixD;

    logic [CNT_W-1:0]  maxCnt;
    logic [NB_W-1:0]   maxBin;
    logic              takeNew;

    // Bin 0 always reloads the running max; strict compare keeps the lowest bin on ties.
    always_comb begin
        takeNew = (binD == '0) || (counts > maxCnt);
    end

    assign raddr     = pixBase + ADDR_W'(binCnt);
    assign rEnable   = (state == READ);
    assign readFlag  = (state == READ);
    assign bld_hold  = (state != IDLE);
    assign scan_done = (state == DONE);
    assign newCounts = '0;

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            binCnt     <= '0;
            pixCnt     <= '0;
            pixBase    <= '0;
            rdValid    <= 1'b0;
            binD       <= '0;
            pixD       <= '0;
            maxCnt     <= '0;
            maxBin     <= '0;
            peak_valid <= 1'b0;
            peak_pixel <= '0;
            peak_bin   <= '0;
            peak_count <= '0;
        end else begin
            rdValid    <= (state == READ);
            binD       <= binCnt;
            pixD       <= pixCnt;
            peak_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= READ;
                        binCnt  <= '0;
                        pixCnt  <= '0;
                        pixBase <= '0;
                    end
                end
                READ: begin
                    if (binCnt == LAST_BIN) begin
                        binCnt <= '0;
                        if (pixCnt == LAST_PIX) begin
                            pixCnt  <= '0;
                            pixBase <= '0;
                            state   <= DRAIN;
                        end else begin
                            pixCnt  <= pixCnt + 1'b1;
                            pixBase <= pixBase + BIN_STEP;
                        end
                    end else begin
                        binCnt <= binCnt + 1'b1;
                    end
                end
                DRAIN:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (rdValid) begin
                if (takeNew) begin
                    maxCnt <= counts;
                    maxBin <= binD;
                end
                if (binD == LAST_BIN) begin
                    peak_valid <= 1'b1;
                    peak_pixel <= pixD;
                    peak_bin   <= takeNew ? binD : maxBin;
                    peak_count <= takeNew ? counts : maxCnt;
                end
            end
        end
    end

`ifdef CLEAR_ON_READ_EN
    logic [ADDR_W-1:0] clrAddr;

    always_ff @(posedge clk) begin
        if (res) begin
            clrAddr <= '0;
        end else begin
            clrAddr <= raddr;
        end
    end

    assign waddr     = clrAddr;
    assign wEnable   = rdValid;
    assign writeFlag = rdValid;
`else
    assign waddr     = '0;
    assign wEnable   = 1'b0;
    assign writeFlag = 1'b0;
`endif

endmodule

// File: tb/tb_his_peak_scheduler.sv
// tb/tb_his_peak_scheduler.sv - self-checking bench for his_peak_scheduler
module tb_his_peak_scheduler;
    localparam int B  = 16;
    localparam int P  = 4;
    localparam int AW = 6;
    localparam int N  = P * B;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    counts = 8'd0;
    logic [AW-1:0] raddr, waddr;
    logic          rEnable, readFlag, wEnable, writeFlag;
    logic [7:0]    newCounts, peak_count;
    logic          bld_hold, peak_valid, scan_done;
    logic [1:0]    peak_pixel;
    logic [3:0]    peak_bin;

    always #5 clk = ~clk;

    his_peak_scheduler #(
        .BIN_NUM(16), .PIXEL_NUM(4), .CNT_W(8), .NB_W(4), .PIX_W(2), .ADDR_W(6)
    ) dut (
        .clk(clk), .res(res), .start(start), .counts(counts),
        .raddr(raddr), .rEnable(rEnable), .readFlag(readFlag),
        .waddr(waddr), .wEnable(wEnable), .writeFlag(writeFlag), .newCounts(newCounts),
        .bld_hold(bld_hold), .peak_valid(peak_valid), .peak_pixel(peak_pixel),
        .peak_bin(peak_bin), .peak_count(peak_count), .scan_done(scan_done)
    );

    logic [7:0] ram [N];
    logic [7:0] img [N];
    logic       loadReq = 1'b0;

    // RAM model: registered read (1-cycle latency), port-a writes, bulk load from img.
    always @(posedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < N; i++) ram[i] <= img[i];
        end else if (wEnable && writeFlag) begin
            ram[waddr] <= newCounts;
        end
        if (rEnable && readFlag) counts <= ram[raddr];
    end

    int total = 0;
    int bad   = 0;
    int expBin [P];
    int expCnt [P];

    typedef struct {
        int bg;
        int binA;
        int valA;
        int binB;
        int valB;
        int eBin;
        int eCnt;
    } pix_rec_t;

    pix_rec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_img();
        @(negedge clk);
        loadReq = 1'b1;
        @(negedge clk);
        loadReq = 1'b0;
    endtask

    task automatic fill_from_table(input int first);
        for (int p = 0; p < P; p++) begin
            for (int b = 0; b < B; b++) img[p*B+b] = 8'(tbl[first+p].bg);
            img[p*B+tbl[first+p].binA] = 8'(tbl[first+p].valA);
            img[p*B+tbl[first+p].binB] = 8'(tbl[first+p].valB);
            expBin[p] = tbl[first+p].eBin;
            expCnt[p] = tbl[first+p].eCnt;
        end
    endtask

    // Reference: first bin holding the largest value of each pixel, taken from the RAM model.
    task automatic model_expect();
        for (int p = 0; p < P; p++) begin
            int best = 0;
            for (int b = 1; b < B; b++)
                if (int'(ram[p*B+b]) > int'(ram[p*B+best])) best = b;
            expBin[p] = best;
            expCnt[p] = int'(ram[p*B+best]);
        end
    endtask

    task automatic check_mem(input string name);
        int err = 0;
        for (int i = 0; i < N; i++) begin
`ifdef CLEAR_ON_READ_EN
            if (ram[i] !== 8'd0) err++;
`else
            if (ram[i] !== img[i]) err++;
`endif
        end
        chk(name, err, 0);
    endtask

    task automatic run_scan(input string tag, input int busyAt, input int resAt);
        int limit;
        int addrErr = 0, holdErr = 0, wrErr = 0, resErr = 0;
        int doneCnt = 0, doneAt = -1, pk = 0;
        int gotPix [P], gotBin [P], gotCnt [P], gotAt [P];
        bit alive, eRd, eHold, eWr;
        limit = (resAt != 0) ? 39 : 70;
        for (int p = 0; p < P; p++) begin
            gotPix[p] = -1; gotBin[p] = -1; gotCnt[p] = -1; gotAt[p] = -1;
        end
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            alive = (resAt == 0) || (n <= resAt);
            eRd   = alive && (n <= 64);
            eHold = alive && (n <= 66);
            eWr   = alive && (n >= 2) && (n <= 65);
            if (rEnable !== eRd || readFlag !== eRd || (eRd && raddr !== AW'(n - 1))) addrErr++;
            if (bld_hold !== eHold) holdErr++;
`ifdef CLEAR_ON_READ_EN
            if (wEnable !== eWr || writeFlag !== eWr || (eWr && waddr !== AW'(n - 2))) wrErr++;
`else
            if (wEnable !== 1'b0 || writeFlag !== 1'b0 || waddr !== '0) wrErr++;
`endif
            if (newCounts !== 8'd0) wrErr++;
            if (scan_done === 1'b1) begin
                doneCnt++;
                doneAt = n;
            end
            if (peak_valid === 1'b1) begin
                if (pk < P) begin
                    gotPix[pk] = int'(peak_pixel);
                    gotBin[pk] = int'(peak_bin);
                    gotCnt[pk] = int'(peak_count);
                    gotAt[pk]  = n;
                end
                pk++;
            end
            if (resAt != 0 && n == resAt + 1) begin
                if (peak_pixel !== '0 || peak_bin !== '0 || peak_count !== '0 ||
                    raddr !== '0 || peak_valid !== 1'b0) resErr++;
            end
            start = (n == busyAt);
            res   = (resAt != 0) && (n == resAt);
        end
        start = 1'b0;
        res   = 1'b0;
        chk({tag, "_raddr_seq"}, addrErr, 0);
        chk({tag, "_bld_hold"}, holdErr, 0);
        chk({tag, "_write_port"}, wrErr, 0);
        if (resAt == 0) begin
            chk({tag, "_peak_pulses"}, pk, P);
            chk({tag, "_done_count"}, doneCnt, 1);
            chk({tag, "_done_cycle"}, doneAt, 66);
            for (int p = 0; p < P; p++) begin
                chk($sformatf("%s_p%0d_cycle", tag, p), gotAt[p], B * (p + 1) + 2);
                chk($sformatf("%s_p%0d_pixel", tag, p), gotPix[p], p);
                chk($sformatf("%s_p%0d_bin", tag, p), gotBin[p], expBin[p]);
                chk($sformatf("%s_p%0d_count", tag, p), gotCnt[p], expCnt[p]);
            end
            chk({tag, "_held_count"}, int'(peak_count), expCnt[P-1]);
        end else begin
            chk({tag, "_no_done"}, doneCnt, 0);
            chk({tag, "_pulses_before_res"}, pk, 1);
            chk({tag, "_outputs_after_res"}, resErr, 0);
        end
    endtask

    initial begin
        int err;
        tbl[0] = '{1,   5,   9,   5,   9,   5,  9};
        tbl[1] = '{0,  15, 200,  15, 200,  15, 200};
        tbl[2] = '{0,   0,   0,   0,   0,   0,  0};
        tbl[3] = '{0,   3,   7,  10,   7,   3,  7};
        tbl[4] = '{0,   0, 255,   1, 255,   0, 255};
        tbl[5] = '{3,  15,   4,   7,   4,   7,  4};
        tbl[6] = '{255, 2,   0,   9,   0,   0, 255};
        tbl[7] = '{10,  0,   2,  15,  11,  15, 11};

        // Reset with a start pulse inside it: outputs stay 0 and no scan begins.
        err = 0;
        @(negedge clk);
        start = 1'b1;
        if ({raddr, rEnable, readFlag, waddr, wEnable, writeFlag, newCounts, bld_hold,
             peak_valid, peak_pixel, peak_bin, peak_count, scan_done} !== '0) err++;
        @(negedge clk);
        start = 1'b0;
        if ({raddr, rEnable, readFlag, waddr, wEnable, writeFlag, newCounts, bld_hold,
             peak_valid, peak_pixel, peak_bin, peak_count, scan_done} !== '0) err++;
        chk("reset_outputs", err, 0);
        res = 1'b0;
        err = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bld_hold !== 1'b0 || rEnable !== 1'b0 || scan_done !== 1'b0) err++;
        end
        chk("reset_no_scan", err, 0);

        for (int t = 0; t < 8; t += 4) begin
            fill_from_table(t);
            load_img();
            run_scan($sformatf("table%0d", t / 4), 0, 0);
            check_mem($sformatf("table%0d_mem", t / 4));
        end

        fill_from_table(0);
        load_img();
        run_scan("busy", 10, 0);

        fill_from_table(0);
        load_img();
        run_scan("midres", 0, 30);
        model_expect();
        run_scan("after_res", 0, 0);
        check_mem("after_res_mem");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++)
                img[i] = 8'($urandom_range(0, (r % 2 == 0) ? 3 : 255));
            load_img();
            model_expect();
            run_scan($sformatf("rand%0d", r), 0, 0);
            check_mem($sformatf("rand%0d_mem", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
